// File: rtl/arm_seq_pkg.sv
// Shared types for the LDM/STM sequencer: FSM states, {P,U} addressing modes
// and the first-transfer address helper.
package arm_seq_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {IDLE, SETUP, XFER, WBASE, FIN} state_t;

  // Encoded as {P,U}
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } mode_t;

  // Lowest address touched; the walk always ascends from here.
  function automatic logic [31:0] first_addr(input mode_t mode, input logic [31:0] base,
                                             input logic [31:0] span, input logic [31:0] stride);
    case (mode)
      MODE_IA: return base;
      MODE_IB: return base + stride;
      MODE_DA: return base - span + stride;
      default: return base - span;
    endcase
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// Command, memory and register-file signals of the LDM/STM sequencer.
// ABORT exists only when SEQ_MOC_TIMEOUT_EN is defined.
interface ldm_stm_sequencer_if;
  logic        START, IS_LOAD, U, P, W, MOC;
  logic [15:0] REG_LIST;
  logic [3:0]  BASE_REG;
  logic [31:0] BASE_ADDR, MEM_DATA_IN, RF_PA;
  logic [3:0]  RF_A, RF_C;
  logic [31:0] RF_WDATA, MEM_ADDR, MEM_DATA_OUT;
  logic        RF_ENABLE, MEM_REQ, MEM_RW, BUSY, DONE;
`ifdef SEQ_MOC_TIMEOUT_EN
  logic        ABORT;
`endif

  modport master (
    input  START, IS_LOAD, REG_LIST, BASE_REG, BASE_ADDR, U, P, W, MOC, MEM_DATA_IN, RF_PA,
    output RF_A, RF_C, RF_WDATA, RF_ENABLE, MEM_ADDR, MEM_DATA_OUT, MEM_REQ, MEM_RW, BUSY, DONE
`ifdef SEQ_MOC_TIMEOUT_EN
    , output ABORT
`endif
  );

  modport slave (
    output START, IS_LOAD, REG_LIST, BASE_REG, BASE_ADDR, U, P, W, MOC, MEM_DATA_IN, RF_PA,
    input  RF_A, RF_C, RF_WDATA, RF_ENABLE, MEM_ADDR, MEM_DATA_OUT, MEM_REQ, MEM_RW, BUSY, DONE
`ifdef SEQ_MOC_TIMEOUT_EN
    , input ABORT
`endif
  );
endinterface

// File: rtl/priority_enc16.sv
// Lowest-set-bit finder: index of the least significant 1 in req, vld when any bit set.
module priority_enc16 (
  input  logic [15:0] req,
  output logic [3:0]  idx,
  output logic        vld
);
  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--)
      if (req[i]) idx = 4'(i);
  end

  assign vld = |req;
endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM multi-register transfer sequencer driving the register file and memory.
// Define SEQ_MOC_TIMEOUT_EN to add the MOC watchdog and the ABORT output.
module ldm_stm_sequencer #(
  parameter int WORD_BYTES = arm_seq_pkg::WORD_BYTES
`ifdef SEQ_MOC_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input logic                 CLK,
  input logic                 RESET,
  ldm_stm_sequencer_if.master bus
);
  import arm_seq_pkg::*;

  localparam logic [31:0] STRIDE = 32'(WORD_BYTES);

  state_t      state;
  mode_t       mode;
  logic [15:0] list, list_next;
  logic [3:0]  base_reg, cur;
  logic [31:0] base, addr, new_base, span;
  logic [4:0]  n;
  logic        is_load, w, wb_en, mem_req, busy, done, cur_vld, xfer_moc;

  priority_enc16 u_penc (.req(list), .idx(cur), .vld(cur_vld));

  always_comb begin
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(list[i]);
  end

  assign span      = 32'(n) * STRIDE;
  assign list_next = list & ~(16'h1 << cur);
  assign xfer_moc  = (state == XFER) && cur_vld && bus.MOC;

`ifdef SEQ_MOC_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] wd_cnt;
  logic          abort, timeout;
  assign timeout   = (state == XFER) && !bus.MOC && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign bus.ABORT = abort;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      mode     <= MODE_DA;
      list     <= '0;
      base_reg <= '0;
      base     <= '0;
      addr     <= '0;
      new_base <= '0;
      is_load  <= 1'b0;
      w        <= 1'b0;
      wb_en    <= 1'b0;
      mem_req  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef SEQ_MOC_TIMEOUT_EN
      wd_cnt   <= '0;
      abort    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SEQ_MOC_TIMEOUT_EN
      abort <= 1'b0;
`endif
      case (state)
        IDLE: if (bus.START) begin
          is_load  <= bus.IS_LOAD;
          list     <= bus.REG_LIST;
          base_reg <= bus.BASE_REG;
          base     <= bus.BASE_ADDR;
          mode     <= mode_t'({bus.P, bus.U});
          w        <= bus.W;
          busy     <= 1'b1;
          state    <= SETUP;
        end
        SETUP: begin
          addr     <= first_addr(mode, base, span, STRIDE);
          new_base <= mode[0] ? base + span : base - span;
          // A loaded base register must not be overwritten by the writeback
          wb_en    <= w && !(is_load && list[base_reg]);
`ifdef SEQ_MOC_TIMEOUT_EN
          wd_cnt   <= '0;
`endif
          if (n == '0) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            mem_req <= 1'b1;
            state   <= XFER;
          end
        end
        XFER: begin
`ifdef SEQ_MOC_TIMEOUT_EN
          wd_cnt <= xfer_moc ? '0 : wd_cnt + 1'b1;
`endif
          if (xfer_moc) begin
            list <= list_next;
            addr <= addr + STRIDE;
            if (list_next == '0) begin
              mem_req <= 1'b0;
              if (wb_en) state <= WBASE;
              else begin
                done  <= 1'b1;
                state <= FIN;
              end
            end
          end
`ifdef SEQ_MOC_TIMEOUT_EN
          else if (timeout) begin
            mem_req <= 1'b0;
            abort   <= 1'b1;
            done    <= 1'b1;
            state   <= FIN;
          end
`endif
        end
        WBASE: begin
          done  <= 1'b1;
          state <= FIN;
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // mem_req is high exactly while in XFER, so it doubles as the transfer qualifier
  assign bus.BUSY         = busy;
  assign bus.DONE         = done;
  assign bus.MEM_REQ      = mem_req;
  assign bus.MEM_RW       = mem_req & is_load;
  assign bus.MEM_ADDR     = mem_req ? addr : '0;
  assign bus.RF_A         = (mem_req && !is_load) ? cur : '0;
  assign bus.MEM_DATA_OUT = (mem_req && !is_load) ? bus.RF_PA : '0;

  always_comb begin
    bus.RF_C      = '0;
    bus.RF_WDATA  = '0;
    bus.RF_ENABLE = 1'b0;
    if (xfer_moc && is_load) begin
      bus.RF_C      = cur;
      bus.RF_WDATA  = bus.MEM_DATA_IN;
      bus.RF_ENABLE = 1'b1;
    end else if (state == WBASE) begin
      bus.RF_C      = base_reg;
      bus.RF_WDATA  = new_base;
      bus.RF_ENABLE = 1'b1;
    end
  end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
Multi-register transfer sequencer for LDM/STM. Sits directly upstream of the register file and drives its read address A, write address C, write data and write ENABLE. Walks a 16-bit register list, steps memory addresses and handshakes each word with memory via MOC. Optionally writes the updated base back to the register file.

Parameters:
WORD_BYTES, 4, address stride per transferred register
TIMEOUT_CYCLES, 64, MOC watchdog limit; used only when SEQ_MOC_TIMEOUT_EN is defined

Ports:
CLK  in  1  rising-edge clock
RESET  in  1  asynchronous, active-low reset
START  in  1  one-cycle pulse; sampled only in IDLE
IS_LOAD  in  1  1=LDM, 0=STM; captured on START
REG_LIST  in  16  bit i set = transfer Ri; captured on START
BASE_REG  in  4  base register number; captured on START
BASE_ADDR  in  32  current base register value; captured on START
U  in  1  1=increment, 0=decrement
P  in  1  1=before, 0=after
W  in  1  base writeback enable
MOC  in  1  memory operation complete, one-cycle pulse
MEM_DATA_IN  in  32  load data, valid when MOC=1
RF_PA  in  32  register file read port data for RF_A
RF_A  out  4  register file read address (store source)
RF_C  out  4  register file write address
RF_WDATA  out  32  register file write data
RF_ENABLE  out  1  register file write enable
MEM_ADDR  out  32  word address
MEM_DATA_OUT  out  32  store data
MEM_REQ  out  1  memory request, held until MOC
MEM_RW  out  1  1=read, 0=write
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle completion pulse
ABORT  out  1  present only with SEQ_MOC_TIMEOUT_EN

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE. All outputs 0, including MEM_REQ, RF_ENABLE, BUSY and DONE. Internal list, address and counter registers are cleared.
- Reset mid-transfer aborts immediately. No further RF writes or memory requests occur. Partially completed transfers are not undone.
- States: IDLE -> SETUP -> XFER -> (WBASE) -> FIN -> IDLE.
- IDLE: START=1 captures all command inputs and moves to SETUP. START in any other state is ignored.
- SETUP (1 cycle):
  - n = popcount(list).
  - First address: IA (U=1,P=0) = base; IB (U=1,P=1) = base+4; DA (U=0,P=0) = base-4n+4; DB (U=0,P=0... P=1) = base-4n.
  - New base = U ? base+4n : base-4n, computed mod 2^32.
  - n=0: go straight to FIN. No memory access and no writeback.
- XFER: cur = lowest set bit of the remaining list. Registers always transfer lowest-numbered to lowest address, in ascending address order.
  - MEM_REQ=1, MEM_ADDR=addr, MEM_RW=IS_LOAD.
  - Store: RF_A=cur, MEM_DATA_OUT=RF_PA (combinational pass-through).
  - On MOC=1 with a load: RF_C=cur, RF_WDATA=MEM_DATA_IN, RF_ENABLE=1, all combinational in the MOC cycle. The register file captures at that CLK edge.
  - On any MOC: clear the cur bit, addr += 4. If the list is now empty, go to WBASE when W=1 and not suppressed, else FIN.
  - MEM_REQ stays high across consecutive transfers. Minimum 1 cycle per word.
- Base in the list:
  - LDM: the loaded value wins and writeback is suppressed.
  - STM: the original base value is stored, because writeback occurs after all stores.
- WBASE (1 cycle): RF_C=BASE_REG, RF_WDATA=new base, RF_ENABLE=1, MEM_REQ=0.
- FIN (1 cycle): DONE=1, BUSY=1. Next state IDLE.
- RF_ENABLE is never asserted outside XFER-with-load-MOC or WBASE.
- MOC outside XFER is ignored.
- Address arithmetic wraps mod 2^32. No alignment checking.

Optional Feature:
- Macro SEQ_MOC_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter runs in XFER and resets on each MOC.
  - When it reaches TIMEOUT_CYCLES without MOC: MEM_REQ drops, no RF write occurs, ABORT pulses 1 cycle together with DONE, and state returns to IDLE. No base writeback.
  - The ABORT port exists.
- Undefined: no counter and no ABORT port. XFER waits for MOC indefinitely.

Decomposition:
- Shared package (arm_seq_pkg):
  - state enum: IDLE, SETUP, XFER, WBASE, FIN
  - WORD_BYTES constant
  - addressing-mode encoding {P,U}
- One sub-module, priority_enc16: 16-bit lowest-set-bit finder producing a 4-bit index and a valid flag. It is reused for cur selection.
- Popcount stays inline.

Test Plan:
- STM IA, base=0x100, list=0x0005, W=1, MOC one cycle after each request -> R0 written to 0x100, R2 to 0x104; WBASE writes 0x108 to BASE_REG; DONE pulses once.
- LDM DB, base=0x200, list=0x8003, MEM_DATA_IN=0xA,0xB,0xC -> addresses 0x1F4, 0x1F8, 0x1FC; R0=0xA, R1=0xB, R15=0xC.
- LDM IB, W=1, BASE_REG=R1, list=0x0002, base=0x40 -> load from 0x44 into R1; no WBASE write.
- list=0x0000, START -> SETUP then FIN; DONE after 2 cycles; MEM_REQ and RF_ENABLE never asserted.
- Assert RESET during XFER with MOC delayed -> outputs 0 immediately; later MOC causes no RF write; next START works normally.
- SEQ_MOC_TIMEOUT_EN, TIMEOUT_CYCLES=8, MOC never asserted -> after 8 XFER cycles ABORT=DONE=1 for 1 cycle, MEM_REQ=0, state IDLE.
